// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single-port data RAM between the pipeline memory
// stage (scalar or N-lane vector accesses) and the host/loader port.
`default_nettype none

module mem_port_arbiter #(
  parameter int AW       = 24,
  parameter int DW       = 24,
  parameter int N        = 6,
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            p_req,
  input  logic            p_we,
  input  logic            p_vec,
  input  logic [AW-1:0]   p_addr,
  input  logic [DW*N-1:0] p_wdata,
  output logic [DW*N-1:0] p_rdata,
  output logic            p_done,
  output logic            p_stall,
  input  logic            h_req,
  input  logic            h_we,
  input  logic [AW-1:0]   h_addr,
  input  logic [DW-1:0]   h_wdata,
  output logic [DW-1:0]   h_rdata,
  output logic            h_done,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int LW = $clog2(N + 1);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD);
  localparam logic [LW-1:0] VEC_BEATS  = LW'(N);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    P_ACC  = 3'd1,
    P_DONE = 3'd2,
    H_ACC  = 3'd3,
    H_DONE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [LW-1:0]     lane_q, lane_d;
  logic [LW-1:0]     beats_q, beats_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [DW*N-1:0]   p_rdata_q, p_rdata_d;
  logic [DW-1:0]     h_rdata_q, h_rdata_d;
  logic [DW*N-1:0]   p_rdata_cap;
  logic              p_capture;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      lane_q    <= '0;
      beats_q   <= '0;
      hold_q    <= '0;
      p_rdata_q <= '0;
      h_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      beats_q   <= beats_d;
      hold_q    <= hold_d;
      p_rdata_q <= p_rdata_d;
      h_rdata_q <= h_rdata_d;
    end
  end

  // Read data arrives one cycle after its strobe, so it lands in lane (lane-1).
  assign p_capture = !p_we && ((state_q == P_ACC && lane_q != '0) || state_q == P_DONE);

  always_comb begin
    p_rdata_cap = p_rdata_q;
    if (p_capture) begin
      for (int i = 0; i < N; i++) begin
        if (i == int'(lane_q) - 1) p_rdata_cap[i*DW +: DW] = mem_rdata;
      end
    end
  end

  // Exposing the captured view makes the last lane valid in the p_done cycle.
  assign p_rdata = p_rdata_cap;
  assign h_rdata = (state_q == H_DONE && !h_we) ? mem_rdata : h_rdata_q;
  assign p_stall = p_req & ~p_done;

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    beats_d   = beats_q;
    hold_d    = hold_q;
    p_rdata_d = p_rdata_cap;
    h_rdata_d = h_rdata_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    p_done    = 1'b0;
    h_done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!h_req) hold_d = '0;
        if (p_req && (!h_req || hold_q < HOLD_LIMIT)) begin
          state_d   = P_ACC;
          lane_d    = '0;
          beats_d   = p_vec ? VEC_BEATS : LW'(1);
          p_rdata_d = '0;
          if (h_req) hold_d = hold_q + 1'b1;
        end else if (h_req) begin
          state_d = H_ACC;
          hold_d  = '0;
        end
      end
      P_ACC: begin
        mem_en   = 1'b1;
        mem_we   = p_we;
        mem_addr = p_addr + {{(AW-LW){1'b0}}, lane_q};
        for (int i = 0; i < N; i++) begin
          if (i == int'(lane_q)) mem_wdata = p_wdata[i*DW +: DW];
        end
        lane_d = lane_q + 1'b1;
        if (lane_q == beats_q - LW'(1)) state_d = P_DONE;
      end
      P_DONE: begin
        p_done  = 1'b1;
        state_d = IDLE;
      end
      H_ACC: begin
        mem_en    = 1'b1;
        mem_we    = h_we;
        mem_addr  = h_addr;
        mem_wdata = h_wdata;
        state_d   = H_DONE;
      end
      H_DONE: begin
        h_done = 1'b1;
        if (!h_we) h_rdata_d = mem_rdata;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench with a behavioural RAM for mem_port_arbiter.
`default_nettype none

module tb_mem_port_arbiter;

  localparam int AW = 24;
  localparam int DW = 24;
  localparam int N  = 6;
  localparam int PW = DW * N;

  logic          clk = 1'b0;
  logic          rst;
  logic          p_req, p_we, p_vec;
  logic [AW-1:0] p_addr;
  logic [PW-1:0] p_wdata;
  logic [PW-1:0] p_rdata;
  logic          p_done, p_stall;
  logic          h_req, h_we;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata, h_rdata;
  logic          h_done;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] ram [logic [AW-1:0]];

  mem_port_arbiter #(.AW(AW), .DW(DW), .N(N), .MAX_HOLD(8)) dut (
    .clk(clk), .rst(rst),
    .p_req(p_req), .p_we(p_we), .p_vec(p_vec), .p_addr(p_addr),
    .p_wdata(p_wdata), .p_rdata(p_rdata), .p_done(p_done), .p_stall(p_stall),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_rdata(h_rdata), .h_done(h_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ram_rd(input logic [AW-1:0] a);
    return ram.exists(a) ? ram[a] : '0;
  endfunction

  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] = mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram_rd(mem_addr);
  end

  task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe_access(input string tag, input logic we, input logic vec,
                             input logic [AW-1:0] addr, input logic [PW-1:0] wdata,
                             input logic [PW-1:0] exp_rdata);
    int beats;
    logic [AW-1:0] ea;
    beats   = vec ? N : 1;
    p_req   = 1'b1;
    p_we    = we;
    p_vec   = vec;
    p_addr  = addr;
    p_wdata = wdata;
    #1;
    check({tag, "_stall0"}, p_stall, 1);
    check({tag, "_en0"}, mem_en, 0);
    for (int i = 0; i < beats; i++) begin
      tick();
      ea = addr + AW'(i);
      check({tag, "_en"}, mem_en, 1);
      check({tag, "_we"}, mem_we, we);
      check({tag, "_addr"}, mem_addr, ea);
      if (we) check({tag, "_wdata"}, mem_wdata, wdata[i*DW +: DW]);
      check({tag, "_stall"}, p_stall, 1);
    end
    tick();
    check({tag, "_done"}, p_done, 1);
    check({tag, "_en_done"}, mem_en, 0);
    check({tag, "_stall_done"}, p_stall, 0);
    if (!we) check({tag, "_rdata"}, p_rdata, exp_rdata);
    p_req = 1'b0;
    tick();
    check({tag, "_done_low"}, p_done, 0);
    if (!we) check({tag, "_rdata_hold"}, p_rdata, exp_rdata);
  endtask

  task automatic host_access(input string tag, input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata);
    h_req   = 1'b1;
    h_we    = we;
    h_addr  = addr;
    h_wdata = wdata;
    #1;
    check({tag, "_en0"}, mem_en, 0);
    tick();
    check({tag, "_en"}, mem_en, 1);
    check({tag, "_we"}, mem_we, we);
    check({tag, "_addr"}, mem_addr, addr);
    if (we) check({tag, "_wdata"}, mem_wdata, wdata);
    tick();
    check({tag, "_done"}, h_done, 1);
    if (!we) check({tag, "_rdata"}, h_rdata, exp_rdata);
    h_req = 1'b0;
    tick();
    check({tag, "_done_low"}, h_done, 0);
    if (!we) check({tag, "_rdata_hold"}, h_rdata, exp_rdata);
  endtask

  initial begin
    int p_before, p_after, h_cnt, strobes, dones;
    bit seen_h;

    rst = 1'b0;
    p_req = 0; p_we = 0; p_vec = 0; p_addr = '0; p_wdata = '0;
    h_req = 0; h_we = 0; h_addr = '0; h_wdata = '0;
    mem_rdata = '0;
    ram[24'h000010] = 24'h00ABCD;
    ram[24'hFFFFFE] = 24'h0000B0;
    ram[24'hFFFFFF] = 24'h0000B1;
    ram[24'h000000] = 24'h0000B2;
    ram[24'h000001] = 24'h0000B3;
    ram[24'h000002] = 24'h0000B4;
    ram[24'h000003] = 24'h0000B5;

    #3;
    check("rst_p_rdata", p_rdata, 0);
    check("rst_h_rdata", h_rdata, 0);
    check("rst_p_done", p_done, 0);
    check("rst_h_done", h_done, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    p_req = 1'b1;
    #1;
    check("rst_stall_follow", p_stall, 1);
    p_req = 1'b0;
    #1;
    check("rst_stall_low", p_stall, 0);
    #7 rst = 1'b1;
    tick();

    pipe_access("scalar_rd", 1'b0, 1'b0, 24'h000010, '0, 144'h00ABCD);

    pipe_access("vec_wr", 1'b1, 1'b1, 24'h000020,
                {24'd6, 24'd5, 24'd4, 24'd3, 24'd2, 24'd1}, '0);
    check("vec_wr_keeps_rdata", p_rdata, 0);
    pipe_access("vec_rd", 1'b0, 1'b1, 24'h000020, '0,
                {24'd6, 24'd5, 24'd4, 24'd3, 24'd2, 24'd1});

    pipe_access("wrap_rd", 1'b0, 1'b1, 24'hFFFFFE, '0,
                {24'hB5, 24'hB4, 24'hB3, 24'hB2, 24'hB1, 24'hB0});

    host_access("h_wr", 1'b1, 24'h000040, 24'h123456, '0);
    check("h_wr_ram", ram_rd(24'h000040), 24'h123456);
    host_access("h_rd", 1'b0, 24'h000040, '0, 24'h123456);

    // Both sides requesting continuously: host must get in after eight pipeline grants.
    p_req = 1; p_we = 0; p_vec = 0; p_addr = 24'h000010;
    h_req = 1; h_we = 0; h_addr = 24'h000040;
    p_before = 0; p_after = 0; h_cnt = 0; seen_h = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (h_done) begin h_cnt++; seen_h = 1; end
      if (p_done) begin
        if (seen_h) p_after++;
        else p_before++;
      end
      if (p_after == 3) break;
    end
    p_req = 0; h_req = 0;
    check("fair_p_before_host", p_before, 8);
    check("fair_host_grants", h_cnt, 1);
    check("fair_p_resumed", p_after, 3);
    check("fair_h_rdata", h_rdata, 24'h123456);
    tick();
    tick();

    // Reset while lane 3 of a vector write is on the bus.
    p_req = 1; p_we = 1; p_vec = 1; p_addr = 24'h000080;
    p_wdata = {24'h16, 24'h15, 24'h14, 24'h13, 24'h12, 24'h11};
    #1;
    repeat (4) tick();
    check("rstmid_lane3_addr", mem_addr, 24'h000083);
    #2 rst = 1'b0;
    #1;
    check("rstmid_mem_en", mem_en, 0);
    check("rstmid_mem_we", mem_we, 0);
    check("rstmid_mem_addr", mem_addr, 0);
    check("rstmid_mem_wdata", mem_wdata, 0);
    check("rstmid_p_done", p_done, 0);
    p_req = 0;
    strobes = 0; dones = 0;
    for (int c = 0; c < 2; c++) begin
      tick();
      if (mem_en) strobes++;
      if (p_done) dones++;
    end
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (mem_en) strobes++;
      if (p_done) dones++;
    end
    check("rstmid_no_strobes", strobes, 0);
    check("rstmid_no_done", dones, 0);
    check("rstmid_lane2_written", ram_rd(24'h000082), 24'h13);
    check("rstmid_lane3_unwritten", ram_rd(24'h000083), 0);
    pipe_access("post_rst_rd", 1'b0, 1'b0, 24'h000082, '0, 144'h13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
